// File: rtl/sprite_compositor.sv
// N-slot sprite compositor: per-slot ROM addressing, colour-key merge over background, per-frame collision flags.
// Latency 3 cycles scan->rgb; no backpressure, one pixel accepted every cycle.
module sprite_compositor #(
  parameter int          N_SLOTS = 8,
  parameter int          SLOT_W  = 3,
  parameter int          SPR_W   = 20,
  parameter int          SPR_H   = 20,
  parameter int          ADDR_W  = 9,
  parameter logic [7:0]  TRANSP  = 8'hE3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [9:0]                  x_ptr,
  input  logic [9:0]                  y_ptr,
  input  logic                        valid,
  input  logic                        frame_start,
  input  logic                        wr_en,
  input  logic [SLOT_W-1:0]           wr_slot,
  input  logic [20:0]                 wr_data,
  output logic [N_SLOTS*ADDR_W-1:0]   spr_addr,
  input  logic [N_SLOTS*8-1:0]        spr_data,
  input  logic [7:0]                  bg_data,
  output logic [7:0]                  rgb,
  output logic                        rgb_valid,
  output logic [N_SLOTS-1:0]          collision
);

  logic [N_SLOTS-1:0] sh_en, sh_en_nxt, act_en;
  logic [9:0]         sh_x [N_SLOTS];
  logic [9:0]         sh_y [N_SLOTS];
  logic [9:0]         sh_x_nxt [N_SLOTS];
  logic [9:0]         sh_y_nxt [N_SLOTS];
  logic [9:0]         act_x [N_SLOTS];
  logic [9:0]         act_y [N_SLOTS];

  logic [N_SLOTS-1:0]        hit_c, hit1, hit2, opaque, overlap;
  logic [N_SLOTS*ADDR_W-1:0] addr_c;
  logic                      vld1, vld2;
  logic [N_SLOTS-1:0]        coll_acc;
  logic [7:0]                win_pix;
  logic [10:0]               x11, y11;

  // Shadow view including this cycle's write, so a write coinciding with frame_start commits immediately.
  always_comb begin
    sh_en_nxt = sh_en;
    sh_x_nxt  = sh_x;
    sh_y_nxt  = sh_y;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (wr_en && wr_slot == SLOT_W'(k)) begin
        sh_en_nxt[k] = wr_data[20];
        sh_x_nxt[k]  = wr_data[19:10];
        sh_y_nxt[k]  = wr_data[9:0];
      end
    end
  end

  assign x11 = {1'b0, x_ptr};
  assign y11 = {1'b0, y_ptr};

  for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
    logic [10:0] sx, sy, dx, dy;
    logic [15:0] lin;
    assign sx  = {1'b0, act_x[k]};
    assign sy  = {1'b0, act_y[k]};
    assign dx  = x11 - sx;
    assign dy  = y11 - sy;
    assign lin = 16'(dy) * 16'(SPR_W) + 16'(dx);
    // 11-bit compares keep sprites near the right/bottom edge from wrapping to column/row 0.
    assign hit_c[k] = act_en[k] & valid & (x11 >= sx) & (x11 < sx + 11'(SPR_W))
                    & (y11 >= sy) & (y11 < sy + 11'(SPR_H));
    assign addr_c[k*ADDR_W +: ADDR_W] = hit_c[k] ? ADDR_W'(lin) : '0;
    assign opaque[k] = hit2[k] & (spr_data[k*8 +: 8] != TRANSP);
  end

  // Lowest index wins: scan downward so slot 0 is applied last.
  always_comb begin
    win_pix = bg_data;
    for (int k = N_SLOTS - 1; k >= 0; k--) begin
      if (opaque[k]) win_pix = spr_data[k*8 +: 8];
    end
  end

  assign overlap = opaque & {{(N_SLOTS-1){opaque[0]}}, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_en     <= '0;
      act_en    <= '0;
      sh_x      <= '{default: '0};
      sh_y      <= '{default: '0};
      act_x     <= '{default: '0};
      act_y     <= '{default: '0};
      spr_addr  <= '0;
      hit1      <= '0;
      hit2      <= '0;
      vld1      <= 1'b0;
      vld2      <= 1'b0;
      rgb       <= 8'h00;
      rgb_valid <= 1'b0;
      collision <= '0;
      coll_acc  <= '0;
    end else begin
      sh_en <= sh_en_nxt;
      sh_x  <= sh_x_nxt;
      sh_y  <= sh_y_nxt;
      if (frame_start) begin
        act_en <= sh_en_nxt;
        act_x  <= sh_x_nxt;
        act_y  <= sh_y_nxt;
      end
      spr_addr  <= addr_c;
      hit1      <= hit_c;
      vld1      <= valid;
      hit2      <= hit1;
      vld2      <= vld1;
      rgb       <= vld2 ? win_pix : 8'h00;
      rgb_valid <= vld2;
      // Overlap seen during the frame_start cycle belongs to the next frame.
      if (frame_start) begin
        collision <= coll_acc;
        coll_acc  <= overlap;
      end else begin
        coll_acc  <= coll_acc | overlap;
      end
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor, instantiated with 6 slots so out-of-range slot writes can be exercised.
module tb_sprite_compositor;
  localparam int NS = 6;
  localparam int AW = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic [9:0]        x_ptr, y_ptr;
  logic              valid, frame_start, wr_en;
  logic [2:0]        wr_slot;
  logic [20:0]       wr_data;
  logic [NS*AW-1:0]  spr_addr;
  logic [NS*8-1:0]   spr_data;
  logic [7:0]        bg_data, rgb;
  logic              rgb_valid;
  logic [NS-1:0]     collision;

  int tests = 0;
  int fails = 0;

  sprite_compositor #(.N_SLOTS(NS), .SLOT_W(3), .SPR_W(20), .SPR_H(20), .ADDR_W(AW), .TRANSP(8'hE3)) dut (
    .clk(clk), .rst(rst), .x_ptr(x_ptr), .y_ptr(y_ptr), .valid(valid),
    .frame_start(frame_start), .wr_en(wr_en), .wr_slot(wr_slot), .wr_data(wr_data),
    .spr_addr(spr_addr), .spr_data(spr_data), .bg_data(bg_data), .rgb(rgb),
    .rgb_valid(rgb_valid), .collision(collision)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input int s, input logic en, input int x, input int y);
    wr_en = 1'b1;
    wr_slot = 3'(s);
    wr_data = {en, 10'(x), 10'(y)};
    step();
    wr_en = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic set_spr(input int k, input logic [7:0] v);
    spr_data[k*8 +: 8] = v;
  endtask

  // One isolated scan point; returns the addresses one cycle later and rgb three cycles later.
  task automatic scan(input int x, input int y, output logic [NS*AW-1:0] a,
                      output logic [7:0] r, output logic rv);
    x_ptr = 10'(x);
    y_ptr = 10'(y);
    valid = 1'b1;
    step();
    a = spr_addr;
    valid = 1'b0;
    step();
    step();
    r = rgb;
    rv = rgb_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests++; if (rgb !== 8'h00) begin fails++; $display("FAIL reset_rgb: got %h want 00", rgb); end
    tests++; if (rgb_valid !== 1'b0) begin fails++; $display("FAIL reset_rgb_valid: got %b want 0", rgb_valid); end
    tests++; if (collision !== '0) begin fails++; $display("FAIL reset_collision: got %b want 0", collision); end
    tests++; if (spr_addr !== '0) begin fails++; $display("FAIL reset_addr: got %h want 0", spr_addr); end
    bg_data = 8'h1C;
    x_ptr = 10'd300;
    y_ptr = 10'd300;
    valid = 1'b1;
    rst = 1'b0;
    step();
    step();
    tests++; if (rgb_valid !== 1'b0) begin fails++; $display("FAIL bg_latency_early: got %b want 0", rgb_valid); end
    step();
    tests++; if (rgb !== 8'h1C || rgb_valid !== 1'b1) begin fails++; $display("FAIL bg_pixel: got %h/%b want 1c/1", rgb, rgb_valid); end
    tests++; if (spr_addr !== '0) begin fails++; $display("FAIL bg_addr: got %h want 0", spr_addr); end
    valid = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_single_sprite();
    logic [NS*AW-1:0] a, e;
    logic [7:0] r;
    logic rv;
    set_spr(2, 8'hFF);
    write_slot(2, 1'b1, 100, 50);
    scan(105, 53, a, r, rv);
    tests++; if (a !== '0 || r !== 8'h1C) begin fails++; $display("FAIL pre_commit: addr %h rgb %h want 0/1c", a, r); end
    frame();
    scan(105, 53, a, r, rv);
    e = '0;
    e[2*AW +: AW] = 9'd65;
    tests++; if (a !== e) begin fails++; $display("FAIL slot2_addr: got %h want %h", a, e); end
    tests++; if (r !== 8'hFF || rv !== 1'b1) begin fails++; $display("FAIL slot2_rgb: got %h/%b want ff/1", r, rv); end
    set_spr(2, 8'hE3);
  endtask

  task automatic test_priority();
    logic [NS*AW-1:0] a, e;
    logic [7:0] r;
    logic rv;
    write_slot(0, 1'b1, 200, 100);
    write_slot(1, 1'b1, 200, 100);
    frame();
    set_spr(0, 8'h03);
    set_spr(1, 8'h18);
    scan(210, 110, a, r, rv);
    e = '0;
    e[0 +: AW] = 9'd210;
    e[AW +: AW] = 9'd210;
    tests++; if (a !== e) begin fails++; $display("FAIL prio_addr: got %h want %h", a, e); end
    tests++; if (r !== 8'h03) begin fails++; $display("FAIL prio_rgb: got %h want 03", r); end
    tests++; if (collision !== 6'b000000) begin fails++; $display("FAIL coll_not_latched: got %b want 000000", collision); end
    frame();
    tests++; if (collision !== 6'b000010) begin fails++; $display("FAIL coll_latched: got %b want 000010", collision); end
    frame();
    tests++; if (collision !== 6'b000000) begin fails++; $display("FAIL coll_cleared: got %b want 000000", collision); end
  endtask

  task automatic test_transparent();
    logic [NS*AW-1:0] a;
    logic [7:0] r;
    logic rv;
    write_slot(1, 1'b0, 200, 100);
    write_slot(3, 1'b1, 200, 100);
    frame();
    set_spr(0, 8'hE3);
    set_spr(3, 8'h40);
    scan(205, 105, a, r, rv);
    tests++; if (r !== 8'h40) begin fails++; $display("FAIL transp_rgb: got %h want 40", r); end
    frame();
    tests++; if (collision !== 6'b000000) begin fails++; $display("FAIL transp_coll: got %b want 000000", collision); end
  endtask

  task automatic test_shadow();
    logic [NS*AW-1:0] a, e;
    logic [7:0] r;
    logic rv;
    write_slot(0, 1'b0, 0, 0);
    write_slot(3, 1'b0, 0, 0);
    for (int k = 0; k < NS; k++) set_spr(k, 8'hE3);
    write_slot(1, 1'b1, 50, 300);
    frame();
    write_slot(1, 1'b1, 200, 300);
    scan(55, 305, a, r, rv);
    e = '0;
    e[AW +: AW] = 9'd105;
    tests++; if (a !== e) begin fails++; $display("FAIL shadow_old_x: got %h want %h", a, e); end
    frame();
    scan(55, 305, a, r, rv);
    tests++; if (a !== '0) begin fails++; $display("FAIL shadow_old_gone: got %h want 0", a); end
    scan(205, 305, a, r, rv);
    tests++; if (a !== e) begin fails++; $display("FAIL shadow_new_x: got %h want %h", a, e); end
    write_slot(7, 1'b1, 400, 400);
    frame();
    scan(405, 405, a, r, rv);
    tests++; if (a !== '0 || r !== 8'h1C) begin fails++; $display("FAIL bad_slot: addr %h rgb %h want 0/1c", a, r); end
    wr_en = 1'b1;
    wr_slot = 3'd4;
    wr_data = {1'b1, 10'd400, 10'd400};
    frame_start = 1'b1;
    step();
    wr_en = 1'b0;
    frame_start = 1'b0;
    scan(401, 402, a, r, rv);
    e = '0;
    e[4*AW +: AW] = 9'd41;
    tests++; if (a !== e) begin fails++; $display("FAIL same_cycle_commit: got %h want %h", a, e); end
  endtask

  task automatic test_edge();
    logic [NS*AW-1:0] a, e;
    logic [7:0] r;
    logic rv;
    logic [7:0] exp_b2b [4];
    exp_b2b = '{8'h1C, 8'h1C, 8'h77, 8'h77};
    write_slot(1, 1'b0, 0, 0);
    write_slot(4, 1'b0, 0, 0);
    write_slot(5, 1'b1, 630, 10);
    frame();
    set_spr(5, 8'h77);
    scan(639, 10, a, r, rv);
    e = '0;
    e[5*AW +: AW] = 9'd9;
    tests++; if (a !== e) begin fails++; $display("FAIL edge_addr: got %h want %h", a, e); end
    tests++; if (r !== 8'h77) begin fails++; $display("FAIL edge_rgb: got %h want 77", r); end
    scan(0, 10, a, r, rv);
    tests++; if (a !== '0 || r !== 8'h1C) begin fails++; $display("FAIL no_wrap: addr %h rgb %h want 0/1c", a, r); end
    y_ptr = 10'd10;
    for (int i = 0; i < 6; i++) begin
      x_ptr = 10'(628 + i);
      valid = (i < 4);
      step();
      if (i >= 2) begin
        tests++;
        if (rgb !== exp_b2b[i-2] || rgb_valid !== 1'b1) begin
          fails++; $display("FAIL b2b_px%0d: got %h/%b want %h/1", i-2, rgb, rgb_valid, exp_b2b[i-2]);
        end
      end
    end
    valid = 1'b0;
    step(); step(); step();
    tests++; if (rgb !== 8'h00 || rgb_valid !== 1'b0) begin fails++; $display("FAIL invalid_out: got %h/%b want 00/0", rgb, rgb_valid); end
  endtask

  task automatic test_midreset();
    x_ptr = 10'd635;
    y_ptr = 10'd12;
    valid = 1'b1;
    step(); step(); step();
    tests++; if (rgb !== 8'h77) begin fails++; $display("FAIL pre_reset_rgb: got %h want 77", rgb); end
    rst = 1'b1;
    step();
    tests++; if (rgb !== 8'h00 || rgb_valid !== 1'b0) begin fails++; $display("FAIL midreset_rgb: got %h/%b want 00/0", rgb, rgb_valid); end
    rst = 1'b0;
    step(); step();
    tests++; if (rgb_valid !== 1'b0) begin fails++; $display("FAIL resume_early: got %b want 0", rgb_valid); end
    step();
    tests++; if (rgb !== 8'h1C || rgb_valid !== 1'b1) begin fails++; $display("FAIL resume_rgb: got %h/%b want 1c/1", rgb, rgb_valid); end
    tests++; if (spr_addr !== '0) begin fails++; $display("FAIL reset_slots_cleared: got %h want 0", spr_addr); end
    valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    x_ptr = '0;
    y_ptr = '0;
    valid = 1'b0;
    frame_start = 1'b0;
    wr_en = 1'b0;
    wr_slot = '0;
    wr_data = '0;
    spr_data = {NS{8'hE3}};
    bg_data = 8'h1C;
    test_reset();
    test_single_sprite();
    test_priority();
    test_transparent();
    test_shadow();
    test_edge();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
